bp_next_pc: RTL



---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_next_pc_ras.sv | 62 ++++++
 rtl/bp_next_pc.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_pkg                                                       |
// | Description : Branch type and direction-counter encodings for bp_next_pc.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bp_pkg;

    typedef logic [1:0] br_type_t;

    localparam br_type_t BR_COND = 2'b00;
    localparam br_type_t BR_CALL = 2'b01;
    localparam br_type_t BR_RET  = 2'b10;
    localparam br_type_t BR_IND  = 2'b11;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    // Saturating 2-bit counter step, range 00..11.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_next_pc_ras.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ras_stack                                                    |
// | Description : Circular return address stack with {count, ptr} checkpoint.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ras_stack #(
    parameter  int RAS_DEPTH = 8,
    localparam int PTRW      = $clog2(RAS_DEPTH),
    localparam int CNTW      = $clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic                 pop,
    input  logic [31:0]          push_addr,
    input  logic                 restore,
    input  logic [PTRW+CNTW-1:0] restore_ckpt,
    output logic [31:0]          top,
    output logic [PTRW+CNTW-1:0] ckpt,
    output logic                 empty
);
    import bp_pkg::*;

    localparam logic [CNTW-1:0] C_FULL = CNTW'(RAS_DEPTH);

    logic [PTRW-1:0] r_ptr;
    logic [CNTW-1:0] r_cnt;
    logic [31:0]     r_stack [RAS_DEPTH];
    logic [PTRW-1:0] w_ptr_inc;

    assign w_ptr_inc = r_ptr + PTRW'(1);
    assign top       = r_stack[r_ptr];
    assign ckpt      = {r_cnt, r_ptr};
    assign empty     = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (restore) begin
            {r_cnt, r_ptr} <= restore_ckpt;
        end else if (push) begin
            // Pointer wraps freely, so a push on a full stack lands on the oldest entry.
            r_ptr <= w_ptr_inc;
            if (r_cnt != C_FULL) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PTRW'(1);
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !restore && push) begin
            r_stack[w_ptr_inc] <= push_addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_next_pc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_next_pc                                                   |
// | Description : Direct-mapped BTB + checkpointable RAS next-fetch-PC unit.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bp_next_pc #(
    parameter  int BTB_ENTRIES = 16,
    parameter  int RAS_DEPTH   = 8,
    parameter  int FETCH_BYTES = 16,
    localparam int IDXW        = $clog2(BTB_ENTRIES),
    localparam int PTRW        = $clog2(RAS_DEPTH),
    localparam int CNTW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fetch_valid,
    input  logic [31:0]          pc,
    output logic [31:0]          next_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [1:0]           pred_type,
    output logic [PTRW+CNTW-1:0] ras_ckpt,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic [1:0]           upd_type,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic [PTRW+CNTW-1:0] redirect_ras_ckpt
);
    import bp_pkg::*;

    localparam int TAGW = 32 - IDXW - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
    logic [31:0]            r_target [BTB_ENTRIES];
    br_type_t               r_type   [BTB_ENTRIES];
    logic [1:0]             r_ctr    [BTB_ENTRIES];

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    br_type_t        w_type;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_ras_top;
    logic            w_ras_empty;

    logic [IDXW-1:0] w_u_idx;
    logic [TAGW-1:0] w_u_tag;
    logic            w_u_hit;
    logic            w_u_alloc;

    assign w_idx      = pc[IDXW+1:2];
    assign w_tag      = pc[31:IDXW+2];
    assign w_type     = r_type[w_idx];
    assign pred_type  = w_type;
    assign pred_hit   = fetch_valid & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign pred_taken = pred_hit & ((w_type != BR_COND) | r_ctr[w_idx][1]);

    assign w_push = pred_taken & (w_type == BR_CALL) & ~redirect_valid;
    assign w_pop  = pred_taken & (w_type == BR_RET) & ~redirect_valid & ~w_ras_empty;

    always_comb begin
        next_pc = pc + 32'(FETCH_BYTES);
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (pred_taken) begin
            next_pc = (w_type == BR_RET && !w_ras_empty) ? w_ras_top : r_target[w_idx];
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .resetn       (resetn),
        .push         (w_push),
        .pop          (w_pop),
        .push_addr    (pc + 32'd4),
        .restore      (redirect_valid),
        .restore_ckpt (redirect_ras_ckpt),
        .top          (w_ras_top),
        .ckpt         (ras_ckpt),
        .empty        (w_ras_empty)
    );

    assign w_u_idx   = upd_pc[IDXW+1:2];
    assign w_u_tag   = upd_pc[31:IDXW+2];
    assign w_u_hit   = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
    assign w_u_alloc = ~w_u_hit & (upd_taken | (upd_type != BR_COND));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= ctr_next(r_ctr[w_u_idx], upd_taken);
            end else if (w_u_alloc) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= upd_taken ? CTR_WT : CTR_WNT;
            end
        end
    end

    // Payload fields carry no reset; they are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (resetn && upd_valid && (w_u_alloc || (w_u_hit && upd_taken))) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= upd_target;
            r_type[w_u_idx]   <= upd_type;
        end
    end

endmodule
`default_nettype wire
